// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit:
//   - default data width (BIT_SIZE) and data-memory word-address width (MEM_SIZE)
//   - req_size encodings (byte / half / word / reserved-as-word)
//   - FSM state enumeration
//   - is_misaligned(): alignment test used when LSU_MISALIGN_TRAP_EN is defined
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam int BIT_SIZE_DEFAULT = 32;
    localparam int MEM_SIZE_DEFAULT = 16;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;  // behaves as a word access

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        RD_CAP   = 3'd3,
        WR_ISSUE = 3'd4
    } lsu_state_e;

    // Half accesses need addr[0]==0, word (and reserved) accesses need addr[1:0]==0.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SIZE_BYTE: mis = 1'b0;
            SIZE_HALF: mis = off[0];
            default:   mis = |off;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/lsu_lane.sv
// ----------------------------------------------------------------------------
// lsu_lane
// Combinational little-endian lane handling.
//   size_i      : access size (lsu_pkg SIZE_*)
//   offset_i    : byte offset within the word (addr[1:0])
//   unsigned_i  : 1 = zero-extend sub-word loads, 0 = sign-extend
//   rdata_i     : word read from data memory
//   wdata_i     : store data, right-aligned
//   load_data_o : extracted and extended load result
//   merged_o    : rdata_i with the addressed lane(s) replaced by store data
// ----------------------------------------------------------------------------
module lsu_lane
    import lsu_pkg::*;
#(
    parameter int BIT_SIZE = BIT_SIZE_DEFAULT
) (
    input  logic [1:0]          size_i,
    input  logic [1:0]          offset_i,
    input  logic                unsigned_i,
    input  logic [BIT_SIZE-1:0] rdata_i,
    input  logic [BIT_SIZE-1:0] wdata_i,
    output logic [BIT_SIZE-1:0] load_data_o,
    output logic [BIT_SIZE-1:0] merged_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[7:0];
        case (offset_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
    end

    assign half_sel = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        load_data_o = rdata_i;
        case (size_i)
            SIZE_BYTE: load_data_o = {{(BIT_SIZE-8){~unsigned_i & byte_sel[7]}}, byte_sel};
            SIZE_HALF: load_data_o = {{(BIT_SIZE-16){~unsigned_i & half_sel[15]}}, half_sel};
            default:   load_data_o = rdata_i;
        endcase
    end

    // Per-byte-lane merge: each lane either keeps the read byte or takes the
    // matching byte of the right-aligned store data.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        logic       lane_we;
        logic [7:0] lane_src;

        always_comb begin
            lane_we  = 1'b0;
            lane_src = wdata_i[7:0];
            case (size_i)
                SIZE_BYTE: begin
                    lane_we  = (offset_i == LANE);
                    lane_src = wdata_i[7:0];
                end
                SIZE_HALF: begin
                    lane_we  = (offset_i[1] == LANE[1]);
                    lane_src = wdata_i[8*(gi%2) +: 8];
                end
                default: begin
                    lane_we  = 1'b1;
                    lane_src = wdata_i[8*gi +: 8];
                end
            endcase
        end

        assign merged_o[8*gi +: 8] = lane_we ? lane_src : rdata_i[8*gi +: 8];
    end

    if (BIT_SIZE > 32) begin : g_upper
        assign merged_o[BIT_SIZE-1:32] = rdata_i[BIT_SIZE-1:32];
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Single-outstanding CPU load/store engine in front of a registered-read data
// memory. Loads and sub-word stores read the addressed word (issue/wait/capture),
// sub-word stores then write back the merged word; word stores write directly.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : request handshake (ready only in IDLE)
//   req_write/size/unsigned/addr/wdata : request attributes
//   rsp_valid/rdata/err: one-cycle registered completion pulse and result
//   DM_Address, DM_en_Read, DM_en_Write, DM_Write_Data, DM_Read_Data : memory side
//
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// accesses complete next cycle with rsp_err=1 and make no memory access;
// otherwise offsets are ignored (access aligned down) and rsp_err is 0.
// ----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int BIT_SIZE = BIT_SIZE_DEFAULT,
    parameter int MEM_SIZE = MEM_SIZE_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [1:0]          req_size,
    input  logic                req_unsigned,
    input  logic [31:0]         req_addr,
    input  logic [BIT_SIZE-1:0] req_wdata,
    output logic                rsp_valid,
    output logic [BIT_SIZE-1:0] rsp_rdata,
    output logic                rsp_err,
    output logic [MEM_SIZE-1:0] DM_Address,
    output logic                DM_en_Read,
    output logic                DM_en_Write,
    output logic [BIT_SIZE-1:0] DM_Write_Data,
    input  logic [BIT_SIZE-1:0] DM_Read_Data
);

    lsu_state_e          state_q, state_d;
    logic [MEM_SIZE-1:0] addr_q, addr_d;
    logic [1:0]          off_q, off_d;
    logic [1:0]          size_q, size_d;
    logic                uns_q, uns_d;
    logic                write_q, write_d;
    logic [BIT_SIZE-1:0] sdata_q, sdata_d;
    logic [BIT_SIZE-1:0] wdata_q, wdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [BIT_SIZE-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
    logic                err_q, err_d;
`endif

    logic                trap;
    logic [BIT_SIZE-1:0] load_data;
    logic [BIT_SIZE-1:0] merged;
    logic                unused_addr_hi;

    // Address bits above the memory's reach are deliberately dropped.
    assign unused_addr_hi = ^req_addr[31:MEM_SIZE+2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = is_misaligned(req_size, req_addr[1:0]);
`else
    assign trap = 1'b0;
`endif

    lsu_lane #(
        .BIT_SIZE (BIT_SIZE)
    ) u_lane (
        .size_i      (size_q),
        .offset_i    (off_q),
        .unsigned_i  (uns_q),
        .rdata_i     (DM_Read_Data),
        .wdata_i     (sdata_q),
        .load_data_o (load_data),
        .merged_o    (merged)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        off_d       = off_q;
        size_d      = size_q;
        uns_d       = uns_q;
        write_d     = write_q;
        sdata_d     = sdata_q;
        wdata_d     = wdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
`ifdef LSU_MISALIGN_TRAP_EN
        err_d       = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (trap) begin
                        // Misaligned: answer immediately, leave the memory alone.
                        rsp_valid_d = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
                        err_d       = 1'b1;
`endif
                    end else begin
                        addr_d  = req_addr[MEM_SIZE+1:2];
                        off_d   = req_addr[1:0];
                        size_d  = req_size;
                        uns_d   = req_unsigned;
                        write_d = req_write;
                        sdata_d = req_wdata;
                        // Reserved size 11 shares the word path (size[1] set).
                        if (req_write && req_size[1]) begin
                            wdata_d = req_wdata;
                            state_d = WR_ISSUE;
                        end else begin
                            state_d = RD_ISSUE;
                        end
                    end
                end
            end
            RD_ISSUE: state_d = RD_WAIT;
            RD_WAIT:  state_d = RD_CAP;
            RD_CAP: begin
                if (write_q) begin
                    wdata_d = merged;
                    state_d = WR_ISSUE;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = load_data;
                    state_d     = IDLE;
                end
            end
            WR_ISSUE: begin
                rsp_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            off_q       <= '0;
            size_q      <= '0;
            uns_q       <= 1'b0;
            write_q     <= 1'b0;
            sdata_q     <= '0;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            off_q       <= off_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            write_q     <= write_d;
            sdata_q     <= sdata_d;
            wdata_q     <= wdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready     = (state_q == IDLE);
    assign DM_en_Read    = (state_q == RD_ISSUE);
    assign DM_en_Write   = (state_q == WR_ISSUE);
    assign DM_Address    = addr_q;
    assign DM_Write_Data = wdata_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_rdata     = rsp_rdata_q;
`ifdef LSU_MISALIGN_TRAP_EN
    assign rsp_err       = err_q;
`else
    assign rsp_err       = 1'b0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit with a registered-read memory model.
// The driver pushes expected responses / memory writes into queues at
// acceptance; monitors pop and compare when rsp_valid / DM_en_Write appear.
// Honours LSU_MISALIGN_TRAP_EN for the misaligned-load case.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] DM_Address;
    logic        DM_en_Read;
    logic        DM_en_Write;
    logic [31:0] DM_Write_Data;
    logic [31:0] DM_Read_Data;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_write     (req_write),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .rsp_valid     (rsp_valid),
        .rsp_rdata     (rsp_rdata),
        .rsp_err       (rsp_err),
        .DM_Address    (DM_Address),
        .DM_en_Read    (DM_en_Read),
        .DM_en_Write   (DM_en_Write),
        .DM_Write_Data (DM_Write_Data),
        .DM_Read_Data  (DM_Read_Data)
    );

    // Memory model: one-cycle registered read, write on strobe.
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q;
    assign DM_Read_Data = rd_q;
    always @(posedge clk) begin
        if (DM_en_Write) mem[DM_Address[9:0]] = DM_Write_Data;
        if (DM_en_Read)  rd_q <= mem[DM_Address[9:0]];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    int overlap = 0;
    int rd_cnt  = 0;

    typedef struct {
        logic [31:0] data;
        logic [15:0] addr;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t rq[$];
    exp_t wq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (rsp_valid) begin
            if (rq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_rsp: got rdata=%h err=%b at cyc %0d, expected none",
                         rsp_rdata, rsp_err, cyc);
            end else begin
                exp_t e;
                e = rq.pop_front();
                $display("rsp: rdata=%h err=%b cyc=%0d (exp %h err %b cyc %0d)",
                         rsp_rdata, rsp_err, cyc, e.data, e.err, e.cyc);
                chk("rsp_rdata", rsp_rdata, e.data);
                chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.err});
                chk("rsp_cycle", cyc, e.cyc);
            end
        end
    end

    // Memory-write monitor
    always @(negedge clk) begin
        if (DM_en_Read) rd_cnt++;
        if (DM_en_Read && DM_en_Write) overlap++;
        if (DM_en_Write) begin
            if (wq.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr=%h data=%h at cyc %0d, expected none",
                         DM_Address, DM_Write_Data, cyc);
            end else begin
                exp_t e;
                e = wq.pop_front();
                $display("mem write: addr=%h data=%h cyc=%0d (exp %h %h cyc %0d)",
                         DM_Address, DM_Write_Data, cyc, e.addr, e.data, e.cyc);
                chk("wr_addr", {16'b0, DM_Address}, {16'b0, e.addr});
                chk("wr_data", DM_Write_Data, e.data);
                chk("wr_cycle", cyc, e.cyc);
            end
        end
    end

    // Issue one request from a negedge; returns at the negedge after acceptance.
    // rsp_lat / wr_lat are cycle indices counted from the acceptance edge (0 = none).
    task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err, input int rsp_lat,
                         input logic [31:0] exp_wd, input int wr_lat,
                         output logic rv_at_accept);
        int n;
        exp_t e;
        req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        rv_at_accept = rsp_valid;
        if (!req_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, n);
            req_valid = 1'b0;
            return;
        end
        if (rsp_lat > 0) begin
            e.data = exp_rd; e.addr = 16'((addr >> 2) & 32'hFFFF); e.err = exp_err; e.cyc = cyc + rsp_lat;
            rq.push_back(e);
        end
        if (wr_lat > 0) begin
            e.data = exp_wd; e.addr = 16'((addr >> 2) & 32'hFFFF); e.err = 1'b0; e.cyc = cyc + wr_lat;
            wq.push_back(e);
        end
        $display("req: wr=%b size=%b uns=%b addr=%h wdata=%h", wr, sz, uns, addr, wd);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((rq.size() != 0 || wq.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (rq.size() != 0 || wq.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: pending rsp=%0d wr=%0d, expected 0", rq.size(), wq.size());
        end
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic f;
        int   r0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        @(negedge clk); @(negedge clk);
        chk("reset_ready", {31'b0, req_ready}, 32'h1);
        chk("reset_outs", {28'b0, rsp_valid, rsp_err, DM_en_Read, DM_en_Write}, 32'h0);
        chk("reset_addr", {16'b0, DM_Address}, 32'h0);
        chk("reset_wdata", DM_Write_Data | rsp_rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Word store: write in cycle 1, response in cycle 2.
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'hDEADBEEF, 1, f);
        drain();

        mem[4] = 32'h80FF7F01;
        issue(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000007F, 1'b0, 4, 32'h0, 0, f);
        issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 4, 32'h0, 0, f);
        issue(1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h00000080, 1'b0, 4, 32'h0, 0, f);
        drain();

        // Sub-word store: read-modify-write, write in cycle 4, response in cycle 5.
        mem[4] = 32'h11223344;
        issue(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000AAAA, 32'h0, 1'b0, 5, 32'hAAAA3344, 4, f);
        drain();
        chk("mem4_after_sh", mem[4], 32'hAAAA3344);

        issue(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 32'hFFFFAAAA, 1'b0, 4, 32'h0, 0, f);
        issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'h00003344, 1'b0, 4, 32'h0, 0, f);
        issue(1'b1, 2'b00, 1'b0, 32'h21, 32'h0000005A, 32'h0, 1'b0, 5, 32'h00005A00, 4, f);
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00005A00, 1'b0, 4, 32'h0, 0, f);
        drain();

        // Misaligned word load.
        r0 = rd_cnt;
`ifdef LSU_MISALIGN_TRAP_EN
        issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 1, 32'h0, 0, f);
        drain();
        chk("misalign_reads", rd_cnt - r0, 0);
`else
        issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'hAAAA3344, 1'b0, 4, 32'h0, 0, f);
        drain();
        chk("misalign_reads", rd_cnt - r0, 1);
`endif

        // Back-to-back: second request accepted in the rsp_valid cycle.
        issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hAAAA3344, 1'b0, 4, 32'h0, 0, f);
        issue(1'b1, 2'b10, 1'b0, 32'h24, 32'h12345678, 32'h0, 1'b0, 2, 32'h12345678, 1, f);
        chk("b2b_accept_in_rsp_cycle", {31'b0, f}, 32'h1);
        issue(1'b0, 2'b11, 1'b0, 32'h24, 32'h0, 32'h12345678, 1'b0, 4, 32'h0, 0, f);
        // Upper address bits beyond the memory range are ignored.
        issue(1'b0, 2'b10, 1'b0, 32'h00040010, 32'h0, 32'hAAAA3344, 1'b0, 4, 32'h0, 0, f);
        drain();

        // Reset during RD_WAIT of a sub-word store: no write, no response.
        issue(1'b1, 2'b00, 1'b0, 32'h10, 32'h000000FF, 32'h0, 1'b0, 0, 32'h0, 0, f);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_ready", {31'b0, req_ready}, 32'h1);
        chk("rst_mid_outs", {29'b0, rsp_valid, DM_en_Read, DM_en_Write}, 32'h0);
        chk("rst_mid_addr", {16'b0, DM_Address}, 32'h0);
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("rst_mem_unchanged", mem[4], 32'hAAAA3344);

        drain();
        chk("no_rd_wr_overlap", overlap, 0);
        chk("rsp_queue_empty", rq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
